// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - byte-serial instruction fetch unit with hold, stall and redirect handling
// Assembles 32-bit little-endian instructions from an 8-bit memory port.
module inst_fetch (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        branch_flag_i,
    input  logic [31:0] branch_target_addr_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic [7:0]  mem_data_i,
    input  logic        mem_ack_i,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o,
    output logic        inst_valid_o,
    output logic        stallreq_o
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        FLUSH = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] fpc_q, fpc_d;
    logic [31:0] tgt_q, tgt_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] flush_tgt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FETCH;
            cnt_q   <= 2'd0;
            fpc_q   <= 32'h0;
            tgt_q   <= 32'h0;
            pc_q    <= 32'h0;
            inst_q  <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fpc_q   <= fpc_d;
            tgt_q   <= tgt_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH: begin
                if (branch_flag_i && !mem_ack_i) begin
                    state_d = FLUSH;
                end else if (branch_flag_i) begin
                    state_d = FETCH;
                end else if (mem_ack_i && cnt_q == 2'd3) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (branch_flag_i || !stall_i) begin
                    state_d = FETCH;
                end
            end
            FLUSH: begin
                if (mem_ack_i) begin
                    state_d = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase
    end

    // A redirect arriving in the same cycle as the flush ack still wins.
    assign flush_tgt = branch_flag_i ? branch_target_addr_i : tgt_q;

    always_comb begin
        cnt_d  = cnt_q;
        fpc_d  = fpc_q;
        tgt_d  = tgt_q;
        pc_d   = pc_q;
        inst_d = inst_q;
        case (state_q)
            FETCH: begin
                if (branch_flag_i) begin
                    if (mem_ack_i) begin
                        fpc_d = branch_target_addr_i;
                        cnt_d = 2'd0;
                    end else begin
                        tgt_d = branch_target_addr_i;
                    end
                end else if (mem_ack_i) begin
                    inst_d[{cnt_q, 3'b000} +: 8] = mem_data_i;
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        pc_d = fpc_q;
                    end
                end
            end
            HOLD: begin
                if (branch_flag_i) begin
                    fpc_d = branch_target_addr_i;
                    cnt_d = 2'd0;
                end else if (!stall_i) begin
                    fpc_d = fpc_q + 32'd4;
                    cnt_d = 2'd0;
                end
            end
            FLUSH: begin
                if (mem_ack_i) begin
                    fpc_d = flush_tgt;
                    cnt_d = 2'd0;
                end else begin
                    tgt_d = flush_tgt;
                end
            end
            default: begin
                cnt_d = 2'd0;
            end
        endcase
    end

    always_comb begin
        mem_req_o    = !rst && (state_q == FETCH || state_q == FLUSH);
        mem_addr_o   = fpc_q + {30'b0, cnt_q};
        inst_valid_o = !rst && (state_q == HOLD);
        stallreq_o   = ~inst_valid_o;
        pc_o         = pc_q;
        inst_o       = inst_q;
    end

endmodule

// File: tb/tb_inst_fetch.sv
// tb/tb_inst_fetch.sv - scoreboard bench for inst_fetch with directed and random stimulus
// The reference tracks which PC must be presented next and derives its word from a memory function.
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        branch = 1'b0;
    logic [31:0] target = 32'h0;
    logic [7:0]  mem_data = 8'h0;
    logic        mem_ack = 1'b0;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic [31:0] pc_o;
    logic [31:0] inst_o;
    logic        inst_valid_o;
    logic        stallreq_o;

    int vectors = 0;
    int miscompares = 0;
    int cycle = 0;
    int ws = 0;
    bit ws_rand = 1'b0;
    int wcnt = 0;

    logic [31:0] exp_q[$];
    logic [31:0] acked_q[$];

    logic        prev_req = 1'b0;
    logic        prev_ack = 1'b0;
    logic        prev_valid = 1'b0;
    logic        prev_rst = 1'b1;
    logic        prev_branch = 1'b0;
    logic [31:0] prev_addr = 32'h0;
    logic [31:0] held_pc = 32'h0;
    logic [31:0] held_inst = 32'h0;

    inst_fetch dut (
        .clk                  (clk),
        .rst                  (rst),
        .stall_i              (stall),
        .branch_flag_i        (branch),
        .branch_target_addr_i (target),
        .mem_req_o            (mem_req_o),
        .mem_addr_o           (mem_addr_o),
        .mem_data_i           (mem_data),
        .mem_ack_i            (mem_ack),
        .pc_o                 (pc_o),
        .inst_o               (inst_o),
        .inst_valid_o         (inst_valid_o),
        .stallreq_o           (stallreq_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle++;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        logic [7:0] t;
        case (a)
            32'd0:   t = 8'h13;
            32'd1:   t = 8'h05;
            32'd2:   t = 8'h10;
            32'd3:   t = 8'h00;
            default: t = (a[7:0] * 8'd37) ^ a[15:8] ^ a[31:24] ^ 8'h5A;
        endcase
        return t;
    endfunction

    function automatic logic [31:0] exp_inst(input logic [31:0] pc);
        return {mem_byte(pc + 32'd3), mem_byte(pc + 32'd2), mem_byte(pc + 32'd1), mem_byte(pc)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // Monitor, reference model and memory responder, in that fixed order each cycle.
    always @(negedge clk) begin
        logic [31:0] e;
        chk("stallreq", {31'b0, stallreq_o}, {31'b0, ~inst_valid_o});
        if (rst) begin
            chk("req_in_reset", {31'b0, mem_req_o}, 32'd0);
        end else if (prev_rst) begin
            chk("rst_valid", {31'b0, inst_valid_o}, 32'd0);
            chk("rst_pc", pc_o, 32'h0);
            chk("rst_inst", inst_o, 32'h0);
            chk("rst_req", {31'b0, mem_req_o}, 32'd1);
            chk("rst_addr", mem_addr_o, 32'h0);
        end
        if (inst_valid_o) chk("req_in_hold", {31'b0, mem_req_o}, 32'd0);
        if (prev_branch && !prev_rst) chk("valid_after_redirect", {31'b0, inst_valid_o}, 32'd0);
        if (mem_req_o && prev_req && !prev_ack && !rst && !prev_rst)
            chk("addr_stable", mem_addr_o, prev_addr);
        if (inst_valid_o && !prev_valid) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL spurious_valid: got pc %h with no expected instruction", pc_o);
            end else begin
                e = exp_q.pop_front();
                held_pc = e;
                held_inst = exp_inst(e);
                chk("present_pc", pc_o, held_pc);
                chk("present_inst", inst_o, held_inst);
            end
        end else if (inst_valid_o && prev_valid) begin
            chk("held_pc", pc_o, held_pc);
            chk("held_inst", inst_o, held_inst);
        end

        if (rst) begin
            exp_q.delete();
            exp_q.push_back(32'h0);
        end else if (branch) begin
            exp_q.delete();
            exp_q.push_back(target);
        end else if (inst_valid_o && !stall) begin
            exp_q.push_back(held_pc + 32'd4);
        end

        if (!mem_req_o) begin
            wcnt = 0;
            mem_ack = 1'b0;
            mem_data = 8'($urandom);
        end else if (wcnt >= ws) begin
            mem_ack = 1'b1;
            mem_data = mem_byte(mem_addr_o);
            wcnt = 0;
            if (ws_rand) ws = $urandom_range(0, 2);
            acked_q.push_back(mem_addr_o);
        end else begin
            mem_ack = 1'b0;
            mem_data = 8'($urandom);
            wcnt++;
        end

        prev_req = mem_req_o;
        prev_ack = mem_ack;
        prev_addr = mem_addr_o;
        prev_valid = inst_valid_o;
        prev_rst = rst;
        prev_branch = branch;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input int bound);
        int n = 0;
        while (!inst_valid_o && n < bound) begin
            @(negedge clk);
            n++;
        end
        if (!inst_valid_o) begin
            vectors++;
            miscompares++;
            $display("FAIL wait_valid: timeout after %0d cycles, got 0 expected 1", bound);
        end
    endtask

    task automatic redirect_and_wait(input logic [31:0] t);
        tick();
        branch = 1'b1;
        target = t;
        @(negedge clk);
        tick();
        branch = 1'b0;
        @(negedge clk);
        wait_valid(100);
        chk("redirect_pc", pc_o, t);
    endtask

    task automatic consume_and_wait();
        tick();
        acked_q.delete();
        stall = 1'b0;
        @(negedge clk);
        tick();
        stall = 1'b1;
        @(negedge clk);
        wait_valid(100);
    endtask

    task automatic chk_acked(input logic [31:0] first);
        chk("acked_count", acked_q.size(), 32'd4);
        for (int i = 0; i < 4 && i < acked_q.size(); i++)
            chk("acked_addr", acked_q[i], first + 32'(i));
    endtask

    initial begin
        int c0;
        logic [31:0] flush_seq [5];
        flush_seq[0] = 32'hA;
        flush_seq[1] = 32'h100;
        flush_seq[2] = 32'h101;
        flush_seq[3] = 32'h102;
        flush_seq[4] = 32'h103;

        repeat (3) tick();
        stall = 1'b1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("boot_addr", mem_addr_o, 32'(i));
            chk("boot_req", {31'b0, mem_req_o}, 32'd1);
        end
        @(negedge clk);
        chk("boot_valid", {31'b0, inst_valid_o}, 32'd1);
        chk("boot_pc", pc_o, 32'h0);
        chk("boot_inst", inst_o, 32'h00100513);

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_pc", pc_o, 32'h0);
            chk("stall_inst", inst_o, 32'h00100513);
            chk("stall_req", {31'b0, mem_req_o}, 32'd0);
        end

        tick();
        ws = 2;
        stall = 1'b0;
        @(negedge clk);
        tick();
        stall = 1'b1;
        @(negedge clk);
        chk("next_addr", mem_addr_o, 32'h4);
        chk("next_req", {31'b0, mem_req_o}, 32'd1);
        c0 = cycle;
        wait_valid(100);
        chk("ws2_latency", 32'(cycle - c0), 32'd12);
        chk("ws2_pc", pc_o, 32'h4);

        tick();
        stall = 1'b0;
        @(negedge clk);
        tick();
        stall = 1'b1;
        begin
            int n = 0;
            @(negedge clk);
            while (mem_addr_o != 32'hA && n < 50) begin
                @(negedge clk);
                n++;
            end
            chk("reach_byte2", mem_addr_o, 32'hA);
        end
        tick();
        branch = 1'b1;
        target = 32'h100;
        @(negedge clk);
        tick();
        branch = 1'b0;
        acked_q.delete();
        @(negedge clk);
        chk("flush_addr", mem_addr_o, 32'hA);
        chk("flush_req", {31'b0, mem_req_o}, 32'd1);
        wait_valid(100);
        chk("flush_acked_count", acked_q.size(), 32'd5);
        for (int i = 0; i < 5 && i < acked_q.size(); i++)
            chk("flush_acked_addr", acked_q[i], flush_seq[i]);
        chk("flush_pc", pc_o, 32'h100);

        tick();
        ws = 0;
        branch = 1'b1;
        target = 32'h40;
        @(negedge clk);
        tick();
        branch = 1'b0;
        @(negedge clk);
        chk("hold_redir_valid", {31'b0, inst_valid_o}, 32'd0);
        chk("hold_redir_addr", mem_addr_o, 32'h40);
        wait_valid(100);
        chk("hold_redir_pc", pc_o, 32'h40);

        redirect_and_wait(32'hFFFFFFFC);
        consume_and_wait();
        chk_acked(32'h0);
        chk("wrap_pc", pc_o, 32'h0);

        tick();
        acked_q.delete();
        redirect_and_wait(32'hFFFFFFFE);
        chk_acked(32'hFFFFFFFE);

        tick();
        stall = 1'b0;
        @(negedge clk);
        tick();
        stall = 1'b1;
        @(negedge clk);
        tick();
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_req", {31'b0, mem_req_o}, 32'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_valid", {31'b0, inst_valid_o}, 32'd0);
        chk("midrst_addr", mem_addr_o, 32'h0);
        wait_valid(100);
        chk("midrst_inst", inst_o, 32'h00100513);

        ws_rand = 1'b1;
        for (int i = 0; i < 500; i++) begin
            tick();
            rst = ($urandom_range(0, 99) == 0);
            stall = $urandom_range(0, 1) == 1;
            branch = ($urandom_range(0, 9) == 0);
            target = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFF8 + 32'($urandom_range(0, 7)) : $urandom;
        end
        tick();
        rst = 1'b0;
        branch = 1'b0;
        stall = 1'b0;
        repeat (40) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 rst  input  1  reset, synchronous, active-high (`RstEnable` = 1'b1).
REQ-003 stall_i  input  1  downstream pipeline stall; presented instruction not consumed this cycle.
REQ-004 branch_flag_i  input  1  redirect request from decode stage.
REQ-005 branch_target_addr_i  input  32  redirect target PC.
REQ-006 mem_req_o  output  1  byte read request to instruction memory.
REQ-007 mem_addr_o  output  32  byte address of the current request.
REQ-008 mem_data_i  input  8  read data byte, valid only when mem_ack_i=1.
REQ-009 mem_ack_i  input  1  request completion; may be asserted in any cycle where mem_req_o=1, including the first.
REQ-010 pc_o  output  32  PC of the presented instruction, to the decode-stage pc_i.
REQ-011 inst_o  output  32  assembled instruction, to the decode-stage inst_i.
REQ-012 inst_valid_o  output  1  pc_o/inst_o hold a complete instruction.
REQ-013 stallreq_o  output  1  fetch cannot supply an instruction this cycle; equals ~inst_valid_o.

Function
REQ-014 The block SHALL use three states: FETCH, HOLD and FLUSH, plus a 2-bit byte counter cnt and a 32-bit fetch PC fpc.
REQ-015 In FETCH, mem_req_o=1 and mem_addr_o=fpc+cnt.
REQ-016 Address and request SHALL remain stable until mem_ack_i=1.
REQ-017 On a FETCH cycle with mem_ack_i=1, mem_data_i SHALL be written into inst_o byte lane cnt (little-endian: cnt=0 -> bits 7:0), and cnt SHALL increment.
REQ-018 With mem_ack_i=1 and cnt=3 in FETCH, the next state SHALL be HOLD with pc_o=fpc and inst_valid_o=1 in the following cycle.
REQ-019 Minimum latency from entering FETCH to inst_valid_o=1 SHALL be 4 cycles, with zero memory wait states.
REQ-020 In HOLD, mem_req_o=0 and pc_o/inst_o SHALL be held stable.
REQ-021 In HOLD with stall_i=0 and branch_flag_i=0, the instruction is consumed: fpc<=fpc+4, cnt<=0, and the next state is FETCH.
REQ-022 In HOLD with stall_i=1, the block SHALL remain in HOLD.
REQ-023 inst_valid_o SHALL be 0 in FETCH and FLUSH.
REQ-024 Redirect with branch_flag_i=1 SHALL take priority over stall_i, and SHALL make inst_valid_o=0 from the next cycle.
REQ-025 Redirect in HOLD, or in FETCH on a cycle with mem_ack_i=1: fpc<=branch_target_addr_i, cnt<=0, next state FETCH; any captured byte is discarded.
REQ-026 Redirect in FETCH on a cycle with mem_ack_i=0: latch the target, hold mem_req_o/mem_addr_o unchanged, and go to FLUSH.
REQ-027 FLUSH: mem_req_o=1 with the original address until mem_ack_i=1.
REQ-028 FLUSH: the acknowledged byte SHALL be discarded; then fpc<=latched target, cnt<=0, next state FETCH.
REQ-029 A further redirect during FLUSH SHALL overwrite the latched target; the last redirect wins.
REQ-030 Address arithmetic SHALL be modulo 2^32: fpc=32'hFFFFFFFC consumed yields fetch from 32'h00000000.
REQ-031 The byte address SHALL wrap the same way.
REQ-032 branch_target_addr_i SHALL be used unaligned as given; no alignment check.
REQ-033 mem_data_i SHALL be ignored when mem_ack_i=0.
REQ-034 mem_ack_i SHALL be ignored when mem_req_o=0.

Reset
REQ-035 rst=1 SHALL have priority over all other inputs.
REQ-036 On rst=1: state FETCH, fpc=32'h00000000, cnt=0, pc_o=32'h0, inst_o=32'h0, inst_valid_o=0; mem_req_o=0 during the reset cycle.
REQ-037 Reset mid-fetch or mid-flush SHALL abandon any outstanding request without waiting for ack.
REQ-038 The first request after reset SHALL be issued in the cycle after rst deasserts, at address 0.

Verification
REQ-039 Zero-wait memory holding 13 05 10 00 at 0..3 -> mem_addr_o 0,1,2,3 on consecutive cycles; cycle 5: inst_valid_o=1, pc_o=0, inst_o=32'h00100513.
REQ-040 stall_i=1 for 3 cycles in HOLD -> pc_o/inst_o unchanged and mem_req_o=0 throughout; on stall_i=0, the next fetch starts at address 4.
REQ-041 Memory with 2 wait states per byte -> mem_addr_o stable while unacked; inst_valid_o=1 12 cycles after the first request.
REQ-042 branch_flag_i=1, target 32'h00000100, while fetching byte 2 unacked -> FLUSH until ack, byte dropped, then requests at 0x100..0x103; pc_o=32'h100.
REQ-043 Redirect in HOLD with stall_i=1, target 32'h40 -> next cycle inst_valid_o=0, mem_addr_o=32'h40.
REQ-044 fpc=32'hFFFFFFFC consumed -> next requests at 0,1,2,3; rst asserted mid-fetch -> next cycle outputs at reset values, new fetch at 0.
